xo_fx_unit: RTL and testbench

Fixed-point execution unit that consumes the XO-format decode bundle (register numbers, 9-bit extended opcode, OE/Rc bits, functional-unit code, enable) and executes it against the register file. Add/subtract-family ops complete in one cycle. Word multiply and divide run a 32-step iterative datapath and backpressure the decoder through `stall_o`. Sits between XO decode and GPR/XER/CR writeback.

---
 rtl/xo_fx_unit_if.sv | 36 +++
 rtl/xo_fx_unit.sv | 208 ++++++++++++++++++++
 tb/tb_xo_fx_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/xo_fx_unit_if.sv
// xo_fx_unit_if: XO decode bundle, register-file read port and writeback bus of the fixed-point unit.
interface xo_fx_unit_if #(
    parameter int XoOpCodeWidth = 9,
    parameter int regWidth = 5,
    parameter int dataWidth = 64
);
    logic                     enable_i;
    logic [regWidth-1:0]      reg1_i, reg2_i, reg3_i;
    logic [XoOpCodeWidth-1:0] xOpCode_i;
    logic                     bit1_i, bit2_i;
    logic [2:0]               functionalUnitCode_i;
    logic [regWidth-1:0]      rfAddrA_o, rfAddrB_o;
    logic [dataWidth-1:0]     rfDataA_i, rfDataB_i;
    logic                     ca_i, so_i;
    logic                     stall_o;
    logic                     wbEnable_o;
    logic [regWidth-1:0]      wbReg_o;
    logic [dataWidth-1:0]     wbData_o;
    logic                     caWrite_o, ca_o, ovWrite_o, ov_o, crWrite_o;
    logic [3:0]               cr0_o;
    logic                     illegal_o;

    modport slave (
        input  enable_i, reg1_i, reg2_i, reg3_i, xOpCode_i, bit1_i, bit2_i, functionalUnitCode_i,
        input  rfDataA_i, rfDataB_i, ca_i, so_i,
        output rfAddrA_o, rfAddrB_o, stall_o, wbEnable_o, wbReg_o, wbData_o,
        output caWrite_o, ca_o, ovWrite_o, ov_o, crWrite_o, cr0_o, illegal_o
    );

    modport master (
        output enable_i, reg1_i, reg2_i, reg3_i, xOpCode_i, bit1_i, bit2_i, functionalUnitCode_i,
        output rfDataA_i, rfDataB_i, ca_i, so_i,
        input  rfAddrA_o, rfAddrB_o, stall_o, wbEnable_o, wbReg_o, wbData_o,
        input  caWrite_o, ca_o, ovWrite_o, ov_o, crWrite_o, cr0_o, illegal_o
    );
endinterface

// File: rtl/xo_fx_unit.sv
// xo_fx_unit: XO-form fixed-point unit; single-cycle add/subtract family, 32-step iterative mullw/divwu/divw.
module xo_fx_unit #(
    parameter logic [2:0] FXUnitCode = 3'd0,
    parameter int XoOpCodeWidth = 9,
    parameter int regWidth = 5,
    parameter int dataWidth = 64
) (
    input logic clock_i,
    input logic resetn_i,
    xo_fx_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;
    localparam logic [XoOpCodeWidth-1:0] OP_ADD = 9'd266, OP_SUBF = 9'd40, OP_ADDC = 9'd10,
        OP_SUBFC = 9'd8, OP_ADDE = 9'd138, OP_SUBFE = 9'd136, OP_ADDME = 9'd234,
        OP_SUBFME = 9'd232, OP_ADDZE = 9'd202, OP_SUBFZE = 9'd200, OP_NEG = 9'd104,
        OP_MULLW = 9'd235, OP_DIVWU = 9'd459, OP_DIVW = 9'd491;

    logic [1:0]               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [63:0]              p_q, p_d;
    logic [31:0]              m_q, m_d;
    logic                     sa_q, sa_d, sb_q, sb_d, oe_q, oe_d, rc_q, rc_d;
    logic [XoOpCodeWidth-1:0] op_q, op_d;
    logic [regWidth-1:0]      rt_q, rt_d, wb_reg_q, wb_reg_d;
    logic [dataWidth-1:0]     wb_data_q, wb_data_d;
    logic                     wb_en_q, wb_en_d, ca_wr_q, ca_wr_d, ca_q, ca_d, ill_q, ill_d;
    logic                     ov_wr_q, ov_wr_d, ov_q, ov_d, cr_wr_q, cr_wr_d;
    logic [3:0]               cr0_q, cr0_d;

    logic [XoOpCodeWidth-1:0] op;
    logic                     accept, inv, use_b, use_m1, cin, single, ca_wr, is_mul, is_div;
    logic [dataWidth-1:0]     a_in, b_in;
    logic [dataWidth:0]       sum;
    logic                     s_ov;

    assign op     = bus.xOpCode_i;
    assign accept = state_q == IDLE && bus.enable_i && bus.functionalUnitCode_i == FXUnitCode;
    assign inv    = op inside {OP_SUBF, OP_SUBFC, OP_SUBFE, OP_SUBFME, OP_SUBFZE, OP_NEG};
    assign use_b  = op inside {OP_ADD, OP_SUBF, OP_ADDC, OP_SUBFC, OP_ADDE, OP_SUBFE};
    assign use_m1 = op inside {OP_ADDME, OP_SUBFME};
    assign single = use_b || use_m1 || op inside {OP_ADDZE, OP_SUBFZE, OP_NEG};
    assign ca_wr  = single && !(op inside {OP_ADD, OP_SUBF, OP_NEG});
    assign is_mul = op == OP_MULLW;
    assign is_div = op == OP_DIVWU || op == OP_DIVW;
    assign cin    = op inside {OP_SUBF, OP_SUBFC, OP_NEG} ||
                    (bus.ca_i && op inside {OP_ADDE, OP_SUBFE, OP_ADDME, OP_SUBFME, OP_ADDZE, OP_SUBFZE});
    assign a_in   = inv ? ~bus.rfDataA_i : bus.rfDataA_i;
    assign b_in   = use_b ? bus.rfDataB_i : use_m1 ? '1 : '0;
    assign sum    = {1'b0, a_in} + {1'b0, b_in} + {{dataWidth{1'b0}}, cin};
    assign s_ov   = a_in[dataWidth-1] == b_in[dataWidth-1] && sum[dataWidth-1] != a_in[dataWidth-1];

    // Iterative ops work on 32-bit magnitudes; signs are kept aside for the DONE fix-up.
    logic        sa, sb;
    logic [31:0] a32, b32, ma, mb;
    assign a32 = bus.rfDataA_i[31:0];
    assign b32 = bus.rfDataB_i[31:0];
    assign sa  = op != OP_DIVWU && a32[31];
    assign sb  = op != OP_DIVWU && b32[31];
    assign ma  = sa ? -a32 : a32;
    assign mb  = sb ? -b32 : b32;

    // p_q is {accumulator/remainder, multiplier/quotient}; m_q holds multiplicand/divisor.
    logic [32:0] add33;
    logic [31:0] diff;
    logic        ge;
    logic [63:0] mul_nx, div_nx;
    assign add33  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
    assign mul_nx = {add33, p_q[31:1]};
    assign ge     = p_q[63:31] >= {1'b0, m_q};
    assign diff   = p_q[62:31] - m_q;
    assign div_nx = {ge ? diff : p_q[62:31], p_q[30:0], ge};

    logic        neg, div_bad, m_ov;
    logic [63:0] prod, m_res;
    logic [31:0] qs;
    assign neg     = sa_q ^ sb_q;
    assign prod    = neg ? -p_q : p_q;
    assign qs      = neg ? -p_q[31:0] : p_q[31:0];
    // Only 0x80000000 / -1 yields a positive signed quotient with bit 31 set.
    assign div_bad = m_q == 32'd0 || (op_q == OP_DIVW && !neg && p_q[31]);
    assign m_res   = op_q == OP_MULLW ? prod : div_bad ? 64'd0 :
                     op_q == OP_DIVW ? {{32{qs[31]}}, qs} : {32'd0, p_q[31:0]};
    assign m_ov    = op_q == OP_MULLW ? !(&prod[63:31] || !(|prod[63:31])) : div_bad;

    function automatic logic [3:0] cr_f(input logic [dataWidth-1:0] r, input logic so);
        return {r[dataWidth-1], !r[dataWidth-1] && |r, ~|r, so};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        p_d = p_q;
        m_d = m_q;
        sa_d = sa_q;
        sb_d = sb_q;
        op_d = op_q;
        rt_d = rt_q;
        oe_d = oe_q;
        rc_d = rc_q;
        wb_en_d = 1'b0;
        wb_reg_d = wb_reg_q;
        wb_data_d = wb_data_q;
        ca_wr_d = 1'b0;
        ca_d = 1'b0;
        ov_wr_d = 1'b0;
        ov_d = 1'b0;
        cr_wr_d = 1'b0;
        cr0_d = cr0_q;
        ill_d = 1'b0;
        if (accept && single) begin
            wb_en_d = 1'b1;
            wb_reg_d = bus.reg1_i;
            wb_data_d = sum[dataWidth-1:0];
            ca_wr_d = ca_wr;
            ca_d = ca_wr && sum[dataWidth];
            ov_wr_d = bus.bit1_i;
            ov_d = bus.bit1_i && s_ov;
            cr_wr_d = bus.bit2_i;
            cr0_d = cr_f(sum[dataWidth-1:0], bus.so_i | ov_d);
        end else if (accept && (is_mul || is_div)) begin
            state_d = is_mul ? MUL : DIV;
            cnt_d = '0;
            p_d = {32'd0, ma};
            m_d = mb;
            sa_d = sa;
            sb_d = sb;
            op_d = op;
            rt_d = bus.reg1_i;
            oe_d = bus.bit1_i;
            rc_d = bus.bit2_i;
        end else if (accept) begin
            ill_d = 1'b1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            wb_en_d = 1'b1;
            wb_reg_d = rt_q;
            wb_data_d = m_res;
            ov_wr_d = oe_q;
            ov_d = oe_q && m_ov;
            cr_wr_d = rc_q;
            cr0_d = cr_f(m_res, bus.so_i | ov_d);
        end else if (state_q != IDLE) begin
            p_d = state_q == MUL ? mul_nx : div_nx;
            cnt_d = cnt_q + 5'd1;
            state_d = cnt_q == 5'd31 ? DONE : state_q;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            p_q <= '0;
            m_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            op_q <= '0;
            rt_q <= '0;
            oe_q <= 1'b0;
            rc_q <= 1'b0;
            wb_en_q <= 1'b0;
            wb_reg_q <= '0;
            wb_data_q <= '0;
            ca_wr_q <= 1'b0;
            ca_q <= 1'b0;
            ov_wr_q <= 1'b0;
            ov_q <= 1'b0;
            cr_wr_q <= 1'b0;
            cr0_q <= '0;
            ill_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            m_q <= m_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            op_q <= op_d;
            rt_q <= rt_d;
            oe_q <= oe_d;
            rc_q <= rc_d;
            wb_en_q <= wb_en_d;
            wb_reg_q <= wb_reg_d;
            wb_data_q <= wb_data_d;
            ca_wr_q <= ca_wr_d;
            ca_q <= ca_d;
            ov_wr_q <= ov_wr_d;
            ov_q <= ov_d;
            cr_wr_q <= cr_wr_d;
            cr0_q <= cr0_d;
            ill_q <= ill_d;
        end
    end

    assign bus.rfAddrA_o  = bus.reg2_i;
    assign bus.rfAddrB_o  = bus.reg3_i;
    assign bus.stall_o    = state_q != IDLE;
    assign bus.wbEnable_o = wb_en_q;
    assign bus.wbReg_o    = wb_reg_q;
    assign bus.wbData_o   = wb_data_q;
    assign bus.caWrite_o  = ca_wr_q;
    assign bus.ca_o       = ca_q;
    assign bus.ovWrite_o  = ov_wr_q;
    assign bus.ov_o       = ov_q;
    assign bus.crWrite_o  = cr_wr_q;
    assign bus.cr0_o      = cr0_q;
    assign bus.illegal_o  = ill_q;
endmodule

// File: tb/tb_xo_fx_unit.sv
// tb_xo_fx_unit: directed vectors with a queued scoreboard checked by an independent writeback monitor.
module tb_xo_fx_unit;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    xo_fx_unit_if bus ();
    xo_fx_unit #(.FXUnitCode(3'd0)) dut (.clock_i(clk), .resetn_i(rstn), .bus(bus));

    typedef struct {
        int          tag;
        logic        ill;
        logic [4:0]  rt;
        logic [63:0] data;
        logic        cawr, ca, ovwr, ov, crwr;
        logic [3:0]  cr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int ntag = 0;

    task automatic chk(input string nm, input int tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s #%0d got=%0h exp=%0h", nm, tag, got, exp);
        end
    endtask

    task automatic drive(input logic [8:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic ca, input logic so, input logic oe, input logic rc, input logic [2:0] fu);
        bus.enable_i = 1'b1;
        bus.xOpCode_i = op;
        bus.rfDataA_i = a;
        bus.rfDataB_i = b;
        bus.ca_i = ca;
        bus.so_i = so;
        bus.bit1_i = oe;
        bus.bit2_i = rc;
        bus.functionalUnitCode_i = fu;
        bus.reg1_i = ntag[4:0];
        bus.reg2_i = 5'(ntag + 1);
        bus.reg3_i = 5'(ntag + 2);
        @(negedge clk);
    endtask

    task automatic op1(input logic [8:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic ca, input logic so, input logic oe, input logic rc,
                       input logic [63:0] data, input logic cawr, input logic cav, input logic ov, input logic [3:0] cr);
        exp_t e;
        ntag++;
        e.tag = ntag;
        e.ill = 1'b0;
        e.rt = ntag[4:0];
        e.data = data;
        e.cawr = cawr;
        e.ca = cav;
        e.ovwr = oe;
        e.ov = ov;
        e.crwr = rc;
        e.cr = cr;
        sb.push_back(e);
        drive(op, a, b, ca, so, oe, rc, 3'd0);
    endtask

    task automatic wait_stall();
        int n = 0;
        while (bus.stall_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("stall_len", ntag, 64'(n), 64'd33);
    endtask

    task automatic multi(input logic [8:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic oe, input logic rc, input logic [63:0] data, input logic ov, input logic [3:0] cr);
        op1(op, a, b, 1'b0, 1'b0, oe, rc, data, 1'b0, 1'b0, ov, cr);
        bus.enable_i = 1'b0;
        wait_stall();
    endtask

    task automatic quiet();
        bus.enable_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (bus.wbEnable_o === 1'b1 || bus.illegal_o === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wb got=%0h exp=none", bus.wbData_o);
                end else begin
                    m = sb.pop_front();
                    chk("illegal", m.tag, bus.illegal_o, m.ill);
                    chk("wb_en", m.tag, bus.wbEnable_o, !m.ill);
                    if (!m.ill) begin
                        chk("wb_reg", m.tag, bus.wbReg_o, m.rt);
                        chk("wb_data", m.tag, bus.wbData_o, m.data);
                        chk("ca_write", m.tag, bus.caWrite_o, m.cawr);
                        if (m.cawr) chk("ca", m.tag, bus.ca_o, m.ca);
                        chk("ov_write", m.tag, bus.ovWrite_o, m.ovwr);
                        chk("ov", m.tag, bus.ov_o, m.ov);
                        chk("cr_write", m.tag, bus.crWrite_o, m.crwr);
                        if (m.crwr) chk("cr0", m.tag, bus.cr0_o, m.cr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rstn = 1'b0;
        bus.enable_i = 1'b0;
        bus.xOpCode_i = '0;
        bus.rfDataA_i = '0;
        bus.rfDataB_i = '0;
        bus.ca_i = 1'b0;
        bus.so_i = 1'b0;
        bus.bit1_i = 1'b0;
        bus.bit2_i = 1'b0;
        bus.functionalUnitCode_i = '0;
        bus.reg1_i = '0;
        bus.reg2_i = '0;
        bus.reg3_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 0, bus.stall_o, 0);
        chk("rst_wb_en", 0, bus.wbEnable_o, 0);
        chk("rst_wb_data", 0, bus.wbData_o, 0);
        chk("rst_ca_write", 0, bus.caWrite_o, 0);
        chk("rst_ov_write", 0, bus.ovWrite_o, 0);
        chk("rst_cr_write", 0, bus.crWrite_o, 0);
        chk("rst_illegal", 0, bus.illegal_o, 0);
        chk("rst_cr0", 0, bus.cr0_o, 0);
        rstn = 1'b1;

        op1(9'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 1, 64'd0, 1, 1, 0, 4'b0010);
        op1(9'd136, 64'd5, 64'd3, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 0, 4'b0000);
        op1(9'd266, 64'd7, 64'd9, 0, 0, 0, 0, 64'd16, 0, 0, 0, 4'b0000);
        chk("single_stall", ntag, bus.stall_o, 0);
        chk("rf_addr_a", ntag, bus.rfAddrA_o, 64'(5'(ntag + 1)));
        op1(9'd40, 64'd3, 64'd10, 0, 0, 0, 1, 64'd7, 0, 0, 0, 4'b0100);
        op1(9'd104, 64'h8000_0000_0000_0000, 64'd0, 0, 0, 1, 1, 64'h8000_0000_0000_0000, 0, 0, 1, 4'b1001);
        op1(9'd138, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 0, 0, 64'd0, 1, 1, 0, 4'b0000);
        op1(9'd234, 64'd0, 64'd0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 4'b1001);
        op1(9'd200, 64'd0, 64'd0, 1, 0, 0, 1, 64'd0, 1, 1, 0, 4'b0010);
        op1(9'd202, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 1, 0, 64'h8000_0000_0000_0000, 1, 0, 1, 4'b0000);
        op1(9'd232, 64'd5, 64'd0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFA, 1, 1, 0, 4'b0000);
        op1(9'd8, 64'd1, 64'd1, 0, 0, 0, 1, 64'd0, 1, 1, 0, 4'b0010);
        op1(9'd266, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 1, 64'h8000_0000_0000_0000, 0, 0, 1, 4'b1001);
        quiet();

        begin : illegal_op
            exp_t e;
            ntag++;
            e.tag = ntag;
            e.ill = 1'b1;
            e.rt = '0;
            e.data = '0;
            e.cawr = 1'b0;
            e.ca = 1'b0;
            e.ovwr = 1'b0;
            e.ov = 1'b0;
            e.crwr = 1'b0;
            e.cr = '0;
            sb.push_back(e);
            drive(9'd74, 64'd1, 64'd2, 0, 0, 0, 0, 3'd0);
        end
        ntag++;
        drive(9'd266, 64'd1, 64'd2, 0, 0, 1, 1, 3'd3);
        chk("nonfx_wb_en", ntag, bus.wbEnable_o, 0);
        chk("nonfx_illegal", ntag, bus.illegal_o, 0);
        chk("nonfx_stall", ntag, bus.stall_o, 0);
        quiet();

        multi(9'd235, 64'hDEAD_BEEF_0001_0000, 64'h1234_5678_0001_0000, 1, 0, 64'h0000_0001_0000_0000, 1, 4'b0000);
        multi(9'd235, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1, 1, 64'hFFFF_FFFF_FFFF_FFF1, 0, 4'b1000);
        multi(9'd459, 64'd100, 64'd7, 0, 0, 64'd14, 0, 4'b0000);
        multi(9'd491, 64'd100, 64'd0, 1, 0, 64'd0, 1, 4'b0000);
        multi(9'd491, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1, 1, 64'hFFFF_FFFF_FFFF_FFF2, 0, 4'b1000);
        multi(9'd491, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 64'd0, 1, 4'b0011);
        multi(9'd459, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1, 64'h0000_0000_FFFF_FFFF, 0, 4'b0100);
        quiet();

        ntag++;
        drive(9'd459, 64'd100, 64'd7, 0, 0, 1, 1, 3'd0);
        bus.enable_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_div_stall", ntag, bus.stall_o, 1);
        rstn = 1'b0;
        #1;
        chk("abort_stall", ntag, bus.stall_o, 0);
        chk("abort_wb_en", ntag, bus.wbEnable_o, 0);
        chk("abort_wb_data", ntag, bus.wbData_o, 0);
        chk("abort_ov_write", ntag, bus.ovWrite_o, 0);
        chk("abort_cr0", ntag, bus.cr0_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        op1(9'd266, 64'd1, 64'd2, 0, 0, 0, 0, 64'd3, 0, 0, 0, 4'b0000);
        repeat (3) quiet();

        chk("sb_empty", 0, 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
